// File: rtl/sha_pkg.sv
// Shared SHA-256 types and constants: block/state word arrays, initial hash
// value, padding constants and the message padder state encoding.
package sha_pkg;

    typedef logic [0:15][31:0] sha_block_t;
    typedef logic [0:7][31:0]  sha_state_t;

    localparam sha_state_t H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [7:0] SHA_PAD_BYTE    = 8'h80;
    localparam int         SHA_LEN_WORD_HI = 14;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_PAD2 = 2'd2,
        ST_EMIT = 2'd3
    } sha_pad_state_e;

endpackage

// File: rtl/sha_pad_word.sv
// Per-word byte masking for the message padder. On the final beat the bytes
// beyond the valid count are cleared and the 0x80 marker is dropped into the
// first free byte; with four valid bytes there is no room, so the marker
// spills into the following word.
module sha_pad_word
    import sha_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    input  logic        last,
    output logic [31:0] word,
    output logic        spill,
    output logic [2:0]  byte_cnt
);

    logic [31:0] keep_mask;
    logic [31:0] pad_bits;

    // Clamp the byte count, then build the keep mask and marker position
    always_comb begin
        byte_cnt = 3'd4;
        if (last && (nbytes < 3'd4)) begin
            byte_cnt = nbytes;
        end
        keep_mask = 32'hFFFF_FFFF;
        pad_bits  = 32'h0;
        case (byte_cnt)
            3'd0: begin
                keep_mask = 32'h0000_0000;
                pad_bits  = {SHA_PAD_BYTE, 24'h0};
            end
            3'd1: begin
                keep_mask = 32'hFF00_0000;
                pad_bits  = {8'h0, SHA_PAD_BYTE, 16'h0};
            end
            3'd2: begin
                keep_mask = 32'hFFFF_0000;
                pad_bits  = {16'h0, SHA_PAD_BYTE, 8'h0};
            end
            3'd3: begin
                keep_mask = 32'hFFFF_FF00;
                pad_bits  = {24'h0, SHA_PAD_BYTE};
            end
            default: begin
                keep_mask = 32'hFFFF_FFFF;
                pad_bits  = 32'h0;
            end
        endcase
        spill = last && (byte_cnt == 3'd4);
        word  = (data & keep_mask) | pad_bits;
    end

endmodule

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and flags the first and
// final block of each message for the downstream compression core.
// Optional build macro SHA_PAD_ABORT_EN adds an 'abort' input that cancels
// the current message and returns the padder to its post-reset state.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high. in_valid/in_data/in_last/in_bytes must hold until accepted;
// blk_valid, blk_W, blk_first and blk_last are held stable by the padder
// until accepted, and blk_valid never drops without acceptance.
module sha_msg_padder
    import sha_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic           clk,
    input  logic           reset,
`ifdef SHA_PAD_ABORT_EN
    input  logic           abort,
`endif
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_data,
    input  logic           in_last,
    input  logic [2:0]     in_bytes,
    output logic           blk_valid,
    input  logic           blk_ready,
    output sha_block_t     blk_W,
    output logic           blk_first,
    output logic           blk_last,
    output sha_pad_state_e dbg_state
);

    sha_pad_state_e    state_q;
    sha_pad_state_e    state_d;
    sha_block_t        blk_w_q;
    logic [3:0]        idx_q;
    logic [LEN_W-1:0]  bit_cnt_q;
    logic              first_q;
    logic              last_q;
    logic              pend_q;     // second (length-only) block still owed
    logic              pad2_80_q;  // second block starts with the 0x80 marker
    logic [3:0]        last_idx_q; // word index of the final data beat
    logic              spill_q;    // 0x80 marker belongs in the next word

    logic [31:0]       pw_word;
    logic              pw_spill;
    logic [2:0]        pw_bytes;
    logic [4:0]        pad_pos;
    logic [63:0]       len64;
    logic              abort_i;

`ifdef SHA_PAD_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    sha_pad_word u_pad_word (
        .data     (in_data),
        .nbytes   (in_bytes),
        .last     (in_last),
        .word     (pw_word),
        .spill    (pw_spill),
        .byte_cnt (pw_bytes)
    );

    // Word index (0..16) where the 0x80 marker lands; 16 means next block
    assign pad_pos = {1'b0, last_idx_q} + {4'b0, spill_q};
    assign len64   = 64'(bit_cnt_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    if (in_last) begin
                        state_d = ST_PAD;
                    end else if (idx_q == 4'd15) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_PAD:  state_d = ST_EMIT;
            ST_PAD2: state_d = ST_EMIT;
            ST_EMIT: begin
                if (blk_ready) begin
                    state_d = pend_q ? ST_PAD2 : ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
        if (abort_i) begin
            state_d = ST_FILL;
        end
    end

    // Outputs decoded from state; flags are only visible while presenting
    always_comb begin
        in_ready  = (state_q == ST_FILL);
        blk_valid = (state_q == ST_EMIT);
        blk_first = (state_q == ST_EMIT) && first_q;
        blk_last  = (state_q == ST_EMIT) && last_q;
        blk_W     = blk_w_q;
        dbg_state = state_q;
    end

    // Block assembly, bit counter and message bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_w_q    <= '0;
            idx_q      <= 4'd0;
            bit_cnt_q  <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            pad2_80_q  <= 1'b0;
            last_idx_q <= 4'd0;
            spill_q    <= 1'b0;
        end else if (abort_i) begin
            blk_w_q    <= '0;
            idx_q      <= 4'd0;
            bit_cnt_q  <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            pad2_80_q  <= 1'b0;
            last_idx_q <= 4'd0;
            spill_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_valid) begin
                        blk_w_q[idx_q] <= pw_word;
                        bit_cnt_q      <= bit_cnt_q + LEN_W'({pw_bytes, 3'b000});
                        idx_q          <= idx_q + 4'd1;
                        last_q         <= 1'b0;
                        if (in_last) begin
                            last_idx_q <= idx_q;
                            spill_q    <= pw_spill;
                        end
                    end
                end
                ST_PAD: begin
                    // Words past the data are already zero (cleared on accept)
                    if (spill_q && (pad_pos < 5'd16)) begin
                        blk_w_q[pad_pos[3:0]] <= {SHA_PAD_BYTE, 24'h0};
                    end
                    if (pad_pos < 5'(SHA_LEN_WORD_HI)) begin
                        blk_w_q[SHA_LEN_WORD_HI]     <= len64[63:32];
                        blk_w_q[SHA_LEN_WORD_HI + 1] <= len64[31:0];
                        last_q    <= 1'b1;
                        pend_q    <= 1'b0;
                        pad2_80_q <= 1'b0;
                    end else begin
                        last_q    <= 1'b0;
                        pend_q    <= 1'b1;
                        pad2_80_q <= (pad_pos == 5'd16);
                    end
                end
                ST_PAD2: begin
                    blk_w_q[0] <= pad2_80_q ? {SHA_PAD_BYTE, 24'h0} : 32'h0;
                    blk_w_q[SHA_LEN_WORD_HI]     <= len64[63:32];
                    blk_w_q[SHA_LEN_WORD_HI + 1] <= len64[31:0];
                    last_q    <= 1'b1;
                    pend_q    <= 1'b0;
                    pad2_80_q <= 1'b0;
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        blk_w_q <= '0;
                        idx_q   <= 4'd0;
                        first_q <= last_q;
                        if (last_q) begin
                            bit_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    idx_q <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for the SHA-256 message padder: hand-computed padded blocks
// for short, boundary-length and multi-block messages, backpressure hold and
// reset in the middle of a message.
module tb_sha_msg_padder;
    import sha_pkg::*;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_data;
    logic           in_last;
    logic [2:0]     in_bytes;
    logic           blk_valid;
    logic           blk_ready;
    sha_block_t     blk_W;
    logic           blk_first;
    logic           blk_last;
    sha_pad_state_e dbg_state;

    int checks   = 0;
    int failures = 0;
    sha_block_t e;

    sha_msg_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_W     (blk_W),
        .blk_first (blk_first),
        .blk_last  (blk_last),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int k);
        return {8'(k + 1), 8'(k + 2), 8'(k + 3), 8'(k + 4)};
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input word and hold it until accepted; returns #1 after the accept edge
    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_words(input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) send_word(pat(k), 1'b0, 3'd4);
    endtask

    // Wait for a block, compare it, accept it, then check in_ready after acceptance
    task automatic expect_block(input string tag, input sha_block_t ew, input logic ef,
                                input logic el, input logic ready_after);
        int n;
        n = 0;
        while (blk_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, blk_valid, 1'b1);
        check({tag, "_W"}, blk_W, ew);
        check({tag, "_first"}, blk_first, ef);
        check({tag, "_last"}, blk_last, el);
        check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        check({tag, "_in_ready_after"}, in_ready, ready_after);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        in_bytes  = 3'd0;
        blk_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_blk_valid", blk_valid, 1'b0);
        check("rst_blk_first", blk_first, 1'b0);
        check("rst_blk_last", blk_last, 1'b0);
        check("rst_blk_W", blk_W, 512'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // "abc": also checks the two-cycle latency to blk_valid
        send_word(32'h61626300, 1'b1, 3'd3);
        check("abc_lat1_valid", blk_valid, 1'b0);
        check("abc_lat1_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("abc_lat2_valid", blk_valid, 1'b1);
        e = '0; e[0] = 32'h61626380; e[15] = 32'h18;
        expect_block("abc", e, 1'b1, 1'b1, 1'b1);

        // Empty message
        send_word(32'hDEADBEEF, 1'b1, 3'd0);
        e = '0; e[0] = 32'h80000000;
        expect_block("empty", e, 1'b1, 1'b1, 1'b1);

        // "hello": junk below the valid byte must be masked
        send_word(32'h68656c6c, 1'b0, 3'd7);
        send_word(32'h6faabbcc, 1'b1, 3'd1);
        e = '0; e[0] = 32'h68656c6c; e[1] = 32'h6f800000; e[15] = 32'h28;
        expect_block("hello", e, 1'b1, 1'b1, 1'b1);

        // 55 bytes: marker lands in W13, still a single block
        send_words(0, 13);
        send_word(pat(13), 1'b1, 3'd3);
        e = '0;
        for (int k = 0; k < 13; k++) e[k] = pat(k);
        e[13] = (pat(13) & 32'hFFFFFF00) | 32'h80; e[15] = 32'h1B8;
        expect_block("b55", e, 1'b1, 1'b1, 1'b1);

        // 56 bytes: marker in W14, length in a second block
        send_words(0, 13);
        send_word(pat(13), 1'b1, 3'd4);
        e = '0;
        for (int k = 0; k < 14; k++) e[k] = pat(k);
        e[14] = 32'h80000000;
        expect_block("b56_1", e, 1'b1, 1'b0, 1'b0);
        e = '0; e[15] = 32'h1C0;
        expect_block("b56_2", e, 1'b0, 1'b1, 1'b1);

        // 60 bytes: marker in W15
        send_words(0, 14);
        send_word(pat(14), 1'b1, 3'd4);
        e = '0;
        for (int k = 0; k < 15; k++) e[k] = pat(k);
        e[15] = 32'h80000000;
        expect_block("b60_1", e, 1'b1, 1'b0, 1'b0);
        e = '0; e[15] = 32'h1E0;
        expect_block("b60_2", e, 1'b0, 1'b1, 1'b1);

        // 64 bytes: marker spills into W0 of the second block
        send_words(0, 15);
        send_word(pat(15), 1'b1, 3'd4);
        e = '0;
        for (int k = 0; k < 16; k++) e[k] = pat(k);
        expect_block("b64_1", e, 1'b1, 1'b0, 1'b0);
        e = '0; e[0] = 32'h80000000; e[15] = 32'h200;
        expect_block("b64_2", e, 1'b0, 1'b1, 1'b1);

        // 68 bytes: a full data block emitted straight from fill
        send_words(0, 16);
        e = '0;
        for (int k = 0; k < 16; k++) e[k] = pat(k);
        expect_block("b68_1", e, 1'b1, 1'b0, 1'b1);
        send_word(pat(16), 1'b1, 3'd4);
        e = '0; e[0] = pat(16); e[1] = 32'h80000000; e[15] = 32'h220;
        expect_block("b68_2", e, 1'b0, 1'b1, 1'b1);

        // Backpressure: block held for 10 cycles
        send_word(32'h61626300, 1'b1, 3'd3);
        @(posedge clk);
        #1;
        e = '0; e[0] = 32'h61626380; e[15] = 32'h18;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", blk_valid, 1'b1);
            check("bp_W", blk_W, e);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        expect_block("bp", e, 1'b1, 1'b1, 1'b1);

        // Reset after 5 words, then "abc" must come out clean
        send_words(20, 5);
        reset = 1'b0;
        #1;
        check("midrst_valid", blk_valid, 1'b0);
        check("midrst_W", blk_W, 512'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        send_word(32'h61626300, 1'b1, 3'd3);
        e = '0; e[0] = 32'h61626380; e[15] = 32'h18;
        expect_block("midrst_abc", e, 1'b1, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- SHA-256 message front end. Accepts a message as a stream of 32-bit big-endian words and performs FIPS 180-4 padding: appends 0x80, zero fill, and the 64-bit bit length.
- Emits complete 512-bit blocks as W[0:15] to the downstream hash core, with first/last block flags so the core knows when to load H0 and when the digest is final.
- Sits directly upstream of the SHA compression/schedule stage.

Parameters:
- LEN_W, 64, width of the internal message bit-length counter; zero-extended to 64 bits in the length field; legal range 16..64.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  input word valid.
- in_ready  out  1  padder can accept an input word.
- in_data  in  32  message word; byte 0 in [31:24].
- in_last  in  1  final word of the message.
- in_bytes  in  3  valid bytes in in_data when in_last=1 (0..4, MSB-aligned); ignored otherwise, treated as 4.
- blk_valid  out  1  output block valid.
- blk_ready  in  1  downstream accepts the block.
- blk_W  out  16x32  block words, packed [0:15][31:0].
- blk_first  out  1  block is the first block of its message.
- blk_last  out  1  block is the final (padded) block of its message.

Behaviour:
- Reset (reset==0, async):
  - State goes to FILL; word index = 0; bit counter = 0; first flag = 1.
  - blk_W is all zeros; blk_valid, blk_first, blk_last = 0.
  - in_ready = 1 once reset deasserts.
  - Reset mid-message discards the partial block and counter; no block is emitted.
- States: FILL, PAD, PAD2, EMIT.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready: store the word at the current index (bytes beyond in_bytes are masked to 0). Add 32 to the counter, or 8*in_bytes on the last beat. Increment the index.
  - Not last and index reaches 16: go to EMIT with blk_last = 0.
  - Last: go to PAD.
- PAD (one cycle, in_ready = 0):
  - Place 0x80 in the byte immediately after the final data byte. If in_bytes = 4 this lands in the next word, at byte [31:24].
  - Zero all remaining words.
  - If the 0x80 byte lies in word 13 or earlier: W14 = length[63:32], W15 = length[31:0]; blk_last = 1; go to EMIT.
  - Otherwise: blk_last = 0; go to EMIT and mark PAD2 pending. This also covers the case where 0x80 would be at word 16, i.e. a full final block; it then becomes W0 of the next block.
- PAD2 (one cycle): build the extra block: optional 0x80000000 in W0, zeros in W1..W13, length in W14/W15; blk_last = 1; go to EMIT.
- EMIT:
  - blk_valid = 1; blk_W and flags held stable until blk_valid & blk_ready.
  - On acceptance: go to PAD2 if pending, else FILL. Reset the index; blk_first = 0 after any accepted block, and back to 1 after an accepted blk_last block. Clear the counter after a blk_last block.
- blk_valid never drops without acceptance.
- Minimum latency from the final input beat to blk_valid is 2 cycles (one extra PAD2 cycle plus the accept cycle when a second block is needed).
- The counter wraps silently modulo 2^LEN_W.

Optional Feature:
- SHA_PAD_ABORT_EN defined: adds input `abort` (1 bit). When sampled high on posedge in any state, the padder returns to the post-reset state on the next cycle: any in-flight block is dropped, blk_valid goes to 0, and no blk_last is produced. abort has priority over in_valid and blk_ready in the same cycle.
- Undefined: no port; a message can only be cancelled by reset.

Decomposition:
- Shared package sha_pkg:
  - typedef `sha_block_t` (logic [0:15][31:0]) and `sha_state_t` (logic [0:7][31:0]);
  - constants `H0`, `SHA_PAD_BYTE` (8'h80), `SHA_LEN_WORD_HI` (14);
  - padder state enum.
- One sub-module, sha_pad_word: combinational; given in_data and in_bytes, produces the masked word plus the 0x80 insertion and a "pad spills to next word" flag.

Test Plan:
- "abc": one beat 0x61626300, in_bytes=3, last -> one block: W0=0x61626380, W1..W14=0, W15=0x18, first=last=1. Feeding the downstream core gives digest ba7816bf...f20015ad.
- Empty message: one beat, in_bytes=0, last -> W0=0x80000000, W15=0, first=last=1.
- 56 bytes (14 full words, last in_bytes=4) -> two blocks:
  - block 1: W14=0x80000000, W15=0, last=0;
  - block 2: W0..W14=0, W15=0x1C0, first=0, last=1.
- 64 bytes (16 words) -> data block (first=1, last=0), then a block with W0=0x80000000 and W15=0x200 (last=1). in_ready stays 0 from the final beat until blk_last is accepted.
- Backpressure: hold blk_ready=0 for 10 cycles during EMIT -> blk_valid=1, blk_W stable, in_ready=0 throughout.
- Assert reset low after 5 words of a message, then send "abc" -> single block identical to the "abc" case with first=1; no stale data appears.
